// File: rtl/riscv_irq_pkg.sv
// Shared types and constants for the CPU-side interrupt responder.
//  - irq_state_e : responder FSM state encoding
//  - NMI_CAUSE   : mcause value reported while an NMI handler runs
//  - int_cause() : mcause value for a maskable source (interrupt bit + source number)
package riscv_irq_pkg;

  localparam int unsigned CORE_XLEN  = 32;
  localparam int unsigned CORE_IRQ_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PEND_INT = 3'd1,
    ST_PEND_NMI = 3'd2,
    ST_TAKE     = 3'd3,
    ST_ISR      = 3'd4,
    ST_NMI_ISR  = 3'd5
  } irq_state_e;

  localparam logic [CORE_XLEN-1:0] NMI_CAUSE = {1'b1, 31'h7FF};

  // Interrupt bit in the MSB, source number in the low bits.
  function automatic logic [CORE_XLEN-1:0] int_cause(input logic [CORE_IRQ_W-1:0] num);
    return {1'b1, {(CORE_XLEN - 1 - CORE_IRQ_W){1'b0}}, num};
  endfunction

endpackage

// File: rtl/irq_responder_if.sv
// Request/redirect bundle between the PIC, the core pipeline and irq_responder.
//  slave  : responder side (takes requests and core status, drives ack/redirect/CSR view)
//  master : environment side (PIC + core)
interface irq_responder_if
  import riscv_irq_pkg::*;
#(
  parameter int unsigned XLEN  = CORE_XLEN,
  parameter int unsigned IRQ_W = CORE_IRQ_W
);
  logic             en_inter;
  logic             en_nmi;
  logic             int_i;
  logic [IRQ_W-1:0] int_num_i;
  logic             nmi_i;
  logic             boundary_i;
  logic [XLEN-1:0]  pc_i;
  logic             mret_i;
  logic             int_ack_o;
  logic [IRQ_W-1:0] ack_num_o;
  logic             redirect_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             flush_o;
  logic [XLEN-1:0]  mepc_o;
  logic [XLEN-1:0]  mcause_o;
  logic             in_service_o;

  modport slave (
    input  en_inter, en_nmi, int_i, int_num_i, nmi_i, boundary_i, pc_i, mret_i,
    output int_ack_o, ack_num_o, redirect_o, redirect_pc_o, flush_o,
           mepc_o, mcause_o, in_service_o
  );

  modport master (
    output en_inter, en_nmi, int_i, int_num_i, nmi_i, boundary_i, pc_i, mret_i,
    input  int_ack_o, ack_num_o, redirect_o, redirect_pc_o, flush_o,
           mepc_o, mcause_o, in_service_o
  );
endinterface

// File: rtl/irq_vector_calc.sv
// Maskable vector address: VEC_BASE + num * VEC_STRIDE, wrapping mod 2^XLEN.
//  num_i : source number
//  vec_c : vector address (combinational)
module irq_vector_calc
  import riscv_irq_pkg::*;
#(
  parameter int unsigned      XLEN       = CORE_XLEN,
  parameter int unsigned      IRQ_W      = CORE_IRQ_W,
  parameter logic [XLEN-1:0]  VEC_BASE   = XLEN'(32'h0000_0040),
  parameter int unsigned      VEC_STRIDE = 4
) (
  input  logic [IRQ_W-1:0] num_i,
  output logic [XLEN-1:0]  vec_c
);

  assign vec_c = VEC_BASE + XLEN'(num_i) * XLEN'(VEC_STRIDE);

endmodule

// File: rtl/irq_responder.sv
// CPU-side interrupt responder: holds PIC / NMI requests until an instruction boundary,
// saves the return PC, acks the PIC, redirects fetch, and restores the PC on mret.
// One nesting level: an NMI may preempt a maskable handler.
//  clk_i : core clock
//  rst   : synchronous reset, active-high
//  bus   : irq_responder_if.slave (requests, boundary/pc/mret in; ack, redirect, CSR view out)
module irq_responder
  import riscv_irq_pkg::*;
#(
  parameter int unsigned      XLEN       = CORE_XLEN,
  parameter int unsigned      IRQ_W      = CORE_IRQ_W,
  parameter logic [XLEN-1:0]  VEC_BASE   = XLEN'(32'h0000_0040),
  parameter int unsigned      VEC_STRIDE = 4,
  parameter logic [XLEN-1:0]  NMI_VEC    = XLEN'(32'h0000_0020)
) (
  input  logic           clk_i,
  input  logic           rst,
  irq_responder_if.slave bus
);

  irq_state_e       state_q, state_d;
  logic [IRQ_W-1:0] num_q, num_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [XLEN-1:0]  nmi_epc_q, nmi_epc_d;
  logic             nested_q, nested_d;
  logic             take_nmi_q, take_nmi_d;
  logic             nmi_pend_q, nmi_pend_d;
  logic             nmi_q;
  logic             int_ack_q, int_ack_d;
  logic [IRQ_W-1:0] ack_num_q, ack_num_d;
  logic             redirect_q, redirect_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0]  mepc_q, mepc_d;
  logic [XLEN-1:0]  mcause_q, mcause_d;
  logic             in_service_q, in_service_d;
  logic [XLEN-1:0]  int_vec_c;
  logic             nmi_rise_c;
  logic             nmi_clr_c;

  irq_vector_calc #(
    .XLEN      (XLEN),
    .IRQ_W     (IRQ_W),
    .VEC_BASE  (VEC_BASE),
    .VEC_STRIDE(VEC_STRIDE)
  ) u_vec (
    .num_i(num_q),
    .vec_c(int_vec_c)
  );

  // nmi_q resets high so an NMI held through reset needs a fresh edge.
  assign nmi_rise_c = bus.nmi_i & ~nmi_q & bus.en_nmi;

  // Next state, capture registers and registered-output values.
  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    epc_d         = epc_q;
    nmi_epc_d     = nmi_epc_q;
    nested_d      = nested_q;
    take_nmi_d    = take_nmi_q;
    nmi_clr_c     = 1'b0;
    int_ack_d     = 1'b0;
    ack_num_d     = '0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (nmi_pend_q) begin
          state_d = ST_PEND_NMI;
        end else if (bus.int_i && bus.en_inter) begin
          state_d = ST_PEND_INT;
          num_d   = bus.int_num_i;
        end
      end
      ST_PEND_INT: begin
        if (!bus.int_i || !bus.en_inter) begin
          state_d = ST_IDLE;
        end else if (nmi_pend_q) begin
          state_d = ST_PEND_NMI;
        end else if (bus.boundary_i) begin
          state_d       = ST_TAKE;
          epc_d         = bus.pc_i;
          take_nmi_d    = 1'b0;
          redirect_d    = 1'b1;
          redirect_pc_d = int_vec_c;
          int_ack_d     = 1'b1;
          ack_num_d     = num_q;
        end
      end
      ST_PEND_NMI: begin
        if (bus.boundary_i) begin
          state_d = ST_TAKE;
          // A preempted maskable handler keeps its epc; the NMI saves into its own slot.
          if (nested_q) nmi_epc_d = bus.pc_i;
          else          epc_d     = bus.pc_i;
          take_nmi_d    = 1'b1;
          nmi_clr_c     = 1'b1;
          redirect_d    = 1'b1;
          redirect_pc_d = NMI_VEC;
        end
      end
      ST_TAKE: begin
        state_d = take_nmi_q ? ST_NMI_ISR : ST_ISR;
      end
      ST_ISR: begin
        // mret outranks a pending NMI; that NMI is then taken from IDLE.
        if (bus.mret_i) begin
          state_d       = ST_IDLE;
          redirect_d    = 1'b1;
          redirect_pc_d = epc_q;
        end else if (nmi_pend_q) begin
          state_d  = ST_PEND_NMI;
          nested_d = 1'b1;
        end
      end
      ST_NMI_ISR: begin
        if (bus.mret_i) begin
          redirect_d    = 1'b1;
          redirect_pc_d = nested_q ? nmi_epc_q : epc_q;
          nested_d      = 1'b0;
          state_d       = nested_q ? ST_ISR : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge in the same cycle as the take stays pending.
    nmi_pend_d = (nmi_pend_q & ~nmi_clr_c) | nmi_rise_c;

    // Handler view tracks the state being entered; a preempted maskable ISR stays
    // visible until the NMI handler actually starts.
    in_service_d = 1'b0;
    mepc_d       = '0;
    mcause_d     = '0;
    if (state_d == ST_NMI_ISR) begin
      in_service_d = 1'b1;
      mepc_d       = nested_d ? nmi_epc_d : epc_d;
      mcause_d     = XLEN'(NMI_CAUSE);
    end else if (state_d == ST_ISR ||
                 ((state_d == ST_PEND_NMI || state_d == ST_TAKE) && nested_d)) begin
      in_service_d = 1'b1;
      mepc_d       = epc_d;
      mcause_d     = XLEN'(int_cause(CORE_IRQ_W'(num_d)));
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      num_q         <= '0;
      epc_q         <= '0;
      nmi_epc_q     <= '0;
      nested_q      <= 1'b0;
      take_nmi_q    <= 1'b0;
      nmi_pend_q    <= 1'b0;
      nmi_q         <= 1'b1;
      int_ack_q     <= 1'b0;
      ack_num_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      in_service_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      epc_q         <= epc_d;
      nmi_epc_q     <= nmi_epc_d;
      nested_q      <= nested_d;
      take_nmi_q    <= take_nmi_d;
      nmi_pend_q    <= nmi_pend_d;
      nmi_q         <= bus.nmi_i;
      int_ack_q     <= int_ack_d;
      ack_num_q     <= ack_num_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      in_service_q  <= in_service_d;
    end
  end

  assign bus.int_ack_o     = int_ack_q;
  assign bus.ack_num_o     = ack_num_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.flush_o       = redirect_q;
  assign bus.mepc_o        = mepc_q;
  assign bus.mcause_o      = mcause_q;
  assign bus.in_service_o  = in_service_q;

endmodule

// File: tb/tb_irq_responder.sv
// Bench for irq_responder. Two instances share one stimulus: the default vector map and
// VEC_BASE=0xFFFF_FFF0 (exercises address wrap). A handler-stack reference model predicts
// redirects into a queue; a negedge monitor pops and compares, and also checks the
// in_service/mepc/mcause view against the model's top-of-stack.
module tb_irq_responder;

  localparam logic [31:0] BASE1   = 32'h0000_0040;
  localparam logic [31:0] BASE2   = 32'hFFFF_FFF0;
  localparam logic [31:0] NMIV    = 32'h0000_0020;
  localparam logic [31:0] NMI_CS  = 32'h8000_07FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_inter = 1'b1, en_nmi = 1'b1, int_i = 1'b0, nmi_i = 1'b0;
  logic [2:0]  int_num = 3'd0;
  logic        boundary = 1'b0, mret = 1'b0;
  logic [31:0] pc = 32'd0;

  always #5 clk = ~clk;

  irq_responder_if #(.XLEN(32), .IRQ_W(3)) bus ();
  irq_responder_if #(.XLEN(32), .IRQ_W(3)) bus2 ();

  assign bus.en_inter   = en_inter;   assign bus2.en_inter   = en_inter;
  assign bus.en_nmi     = en_nmi;     assign bus2.en_nmi     = en_nmi;
  assign bus.int_i      = int_i;      assign bus2.int_i      = int_i;
  assign bus.int_num_i  = int_num;    assign bus2.int_num_i  = int_num;
  assign bus.nmi_i      = nmi_i;      assign bus2.nmi_i      = nmi_i;
  assign bus.boundary_i = boundary;   assign bus2.boundary_i = boundary;
  assign bus.pc_i       = pc;         assign bus2.pc_i       = pc;
  assign bus.mret_i     = mret;       assign bus2.mret_i     = mret;

  irq_responder #(.XLEN(32), .IRQ_W(3), .VEC_BASE(BASE1), .VEC_STRIDE(4), .NMI_VEC(NMIV))
    dut (.clk_i(clk), .rst(rst), .bus(bus));
  irq_responder #(.XLEN(32), .IRQ_W(3), .VEC_BASE(BASE2), .VEC_STRIDE(4), .NMI_VEC(NMIV))
    dut2 (.clk_i(clk), .rst(rst), .bus(bus2));

  // ---------------- reference model ----------------
  typedef struct { bit is_nmi; logic [31:0] epc; logic [2:0] num; } hrec_t;
  typedef struct { int cyc; logic [31:0] pc; logic [31:0] pc2; bit ack; logic [2:0] num; } exp_t;
  typedef enum int { W_NONE, W_INT, W_NMI } wait_e;

  hrec_t hstack[$];
  exp_t  exp_q[$];
  hrec_t incoming;
  wait_e waiting = W_NONE;
  bit    busy = 0, pend = 0, nmi_prev = 1, rise, took;
  logic [2:0] pnum = 3'd0;
  int    cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      hstack.delete();
      waiting = W_NONE; busy = 0; pend = 0; nmi_prev = 1;
    end else begin
      rise = nmi_i && !nmi_prev && en_nmi;
      took = 0;
      if (busy) begin
        hstack.push_back(incoming);
        busy = 0;
      end else if (waiting == W_NMI) begin
        if (boundary) begin
          incoming = '{1'b1, pc, 3'd0};
          exp_q.push_back('{cyc, NMIV, NMIV, 1'b0, 3'd0});
          busy = 1; took = 1; waiting = W_NONE;
        end
      end else if (waiting == W_INT) begin
        if (!int_i || !en_inter) waiting = W_NONE;
        else if (pend) waiting = W_NMI;
        else if (boundary) begin
          incoming = '{1'b0, pc, pnum};
          exp_q.push_back('{cyc, BASE1 + 32'(pnum) * 32'd4, BASE2 + 32'(pnum) * 32'd4, 1'b1, pnum});
          busy = 1; waiting = W_NONE;
        end
      end else if (hstack.size() == 0) begin
        if (pend) waiting = W_NMI;
        else if (int_i && en_inter) begin waiting = W_INT; pnum = int_num; end
      end else if (mret) begin
        exp_q.push_back('{cyc, hstack[$].epc, hstack[$].epc, 1'b0, 3'd0});
        void'(hstack.pop_back());
      end else if (!hstack[$].is_nmi && pend) begin
        waiting = W_NMI;
      end
      pend = (pend && !took) || rise;
      nmi_prev = nmi_i;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int    n_checks = 0, n_err = 0;
  bit    mon_en = 0;
  exp_t  e_mon;
  bit          m_srv;
  logic [31:0] m_epc, m_cause;

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (bus.redirect_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL redirect_spurious: cyc=%0d got pc=%h ack=%b, none expected",
                   cyc, bus.redirect_pc_o, bus.int_ack_o);
        end else begin
          e_mon = exp_q.pop_front();
          if (e_mon.cyc != cyc || bus.redirect_pc_o !== e_mon.pc || bus2.redirect_o !== 1'b1 ||
              bus2.redirect_pc_o !== e_mon.pc2 || bus.flush_o !== 1'b1 ||
              bus.int_ack_o !== e_mon.ack || (e_mon.ack && bus.ack_num_o !== e_mon.num)) begin
            n_err++;
            $display("FAIL redirect: cyc=%0d pc=%h pc2=%h flush=%b ack=%b num=%0d, want cyc=%0d pc=%h pc2=%h flush=1 ack=%b num=%0d",
                     cyc, bus.redirect_pc_o, bus2.redirect_pc_o, bus.flush_o, bus.int_ack_o,
                     bus.ack_num_o, e_mon.cyc, e_mon.pc, e_mon.pc2, e_mon.ack, e_mon.num);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e_mon = exp_q.pop_front();
        n_err++;
        $display("FAIL redirect_missing: cyc=%0d got none, want pc=%h ack=%b", cyc, e_mon.pc, e_mon.ack);
      end else if (bus.flush_o !== 1'b0 || bus.int_ack_o !== 1'b0 || bus2.redirect_o !== 1'b0) begin
        n_err++;
        $display("FAIL pulse_idle: cyc=%0d flush=%b ack=%b redirect2=%b, want 0",
                 cyc, bus.flush_o, bus.int_ack_o, bus2.redirect_o);
      end

      m_srv = hstack.size() > 0;
      m_epc = m_srv ? hstack[$].epc : 32'd0;
      m_cause = !m_srv ? 32'd0 : hstack[$].is_nmi ? NMI_CS : (32'h8000_0000 | 32'(hstack[$].num));
      n_checks++;
      if (bus.in_service_o !== m_srv || bus.mepc_o !== m_epc || bus.mcause_o !== m_cause) begin
        n_err++;
        $display("FAIL status: cyc=%0d in_service=%b mepc=%h mcause=%h, want %b %h %h",
                 cyc, bus.in_service_o, bus.mepc_o, bus.mcause_o, m_srv, m_epc, m_cause);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (bus.int_ack_o !== 1'b0 || bus.ack_num_o !== 3'd0 || bus.redirect_o !== 1'b0 ||
        bus.redirect_pc_o !== 32'd0 || bus.flush_o !== 1'b0 || bus.mepc_o !== 32'd0 ||
        bus.mcause_o !== 32'd0 || bus.in_service_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s: ack=%b num=%0d redir=%b rpc=%h flush=%b mepc=%h mcause=%h srv=%b, want all 0",
               name, bus.int_ack_o, bus.ack_num_o, bus.redirect_o, bus.redirect_pc_o,
               bus.flush_o, bus.mepc_o, bus.mcause_o, bus.in_service_o);
    end
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    check_zero("reset_outputs");
    mon_en = 1'b1;

    // maskable source 5, boundary at pc 0x100, then mret
    int_i = 1; int_num = 3'd5; step(1);
    boundary = 1; pc = 32'h100; step(1);
    boundary = 0; int_i = 0; step(3);
    mret = 1; step(1); mret = 0; step(3);

    // NMI and int together: NMI first, int after mret
    nmi_i = 1; int_i = 1; int_num = 3'd3; step(1);
    boundary = 1; pc = 32'h200; step(2);
    boundary = 0; nmi_i = 0; step(3);
    mret = 1; step(1); mret = 0; step(1);
    boundary = 1; pc = 32'h300; step(1);
    boundary = 0; int_i = 0; step(3);
    mret = 1; step(1); mret = 0; step(2);

    // NMI preempts maskable source 7 (wraps on the second instance)
    int_i = 1; int_num = 3'd7; step(1);
    boundary = 1; pc = 32'h100; step(1);
    boundary = 0; int_i = 0; step(2);
    nmi_i = 1; step(2);
    boundary = 1; pc = 32'h58; step(1);
    boundary = 0; nmi_i = 0; step(3);
    mret = 1; step(1); mret = 0; step(2);
    mret = 1; step(1); mret = 0; step(2);

    // int drops before a boundary: no ack, no redirect
    int_i = 1; int_num = 3'd1; step(1);
    int_i = 0; step(3);

    // reset in ISR with NMI held high through reset
    int_i = 1; int_num = 3'd2; step(1);
    boundary = 1; pc = 32'h400; step(1);
    boundary = 0; int_i = 0; step(2);
    nmi_i = 1; rst = 1; step(1);
    rst = 0;
    check_zero("reset_in_isr");
    mret = 1; step(1); mret = 0;
    boundary = 1; step(3);
    boundary = 0; nmi_i = 0; step(2);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en_inter = ($urandom_range(0, 9) != 0);
      en_nmi   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) int_i = ~int_i;
      if ($urandom_range(0, 3) == 0) int_num = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) nmi_i = ~nmi_i;
      boundary = ($urandom_range(0, 2) == 0);
      pc       = 32'($urandom) & 32'hFFFF_FFFC;
      mret     = ($urandom_range(0, 9) == 0);
      step(1);
    end

    rst = 0; int_i = 0; nmi_i = 0; boundary = 0; mret = 0;
    step(4);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected redirects never seen, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
